// File: rtl/bsg_fpu_classify_pkg.sv
// Shared definitions for the pipelined floating-point classifier.
// Holds the class bit indices of the RISC-V fclass one-hot and the
// decoder output struct.
package bsg_fpu_classify_pkg;

    localparam int class_neg_inf_lp      = 0;
    localparam int class_neg_normal_lp   = 1;
    localparam int class_neg_denormal_lp = 2;
    localparam int class_neg_zero_lp     = 3;
    localparam int class_pos_zero_lp     = 4;
    localparam int class_pos_denormal_lp = 5;
    localparam int class_pos_normal_lp   = 6;
    localparam int class_pos_inf_lp      = 7;
    localparam int class_snan_lp         = 8;
    localparam int class_qnan_lp         = 9;
    localparam int class_count_lp        = 10;

    typedef struct packed {
        logic zero;
        logic denormal;
        logic infty;
        logic nan;
        logic snan;
        logic sign;
    } bsg_fpu_classify_s;

endpackage

// File: rtl/bsg_fpu_classify_decode.sv
// Combinational decode of an IEEE-style operand {sign, exp, man} into
// the classification struct and the 10-bit fclass one-hot.
module bsg_fpu_classify_decode
    import bsg_fpu_classify_pkg::*;
#(
    parameter int e_p = 5,
    parameter int m_p = 10
) (
    input  logic [e_p+m_p:0]          a_i,
    output bsg_fpu_classify_s         decode_o,
    output logic [class_count_lp-1:0] class_o
);

    logic           sign;
    logic [e_p-1:0] expo;
    logic [m_p-1:0] man;

    assign {sign, expo, man} = a_i;

    // Field tests, class flags and one-hot encoding; NaN bits ignore the sign.
    always_comb begin
        logic exp_zero, exp_ones, man_zero, normal;

        exp_zero = (expo == '0);
        exp_ones = (&expo);
        man_zero = (man == '0);

        decode_o          = '0;
        decode_o.sign     = sign;
        decode_o.zero     = exp_zero & man_zero;
        decode_o.denormal = exp_zero & ~man_zero;
        decode_o.infty    = exp_ones & man_zero;
        decode_o.nan      = exp_ones & ~man_zero;
        decode_o.snan     = decode_o.nan & ~man[m_p-1];

        normal = ~(decode_o.zero | decode_o.denormal | decode_o.infty | decode_o.nan);

        class_o                        = '0;
        class_o[class_neg_inf_lp]      = sign  & decode_o.infty;
        class_o[class_neg_normal_lp]   = sign  & normal;
        class_o[class_neg_denormal_lp] = sign  & decode_o.denormal;
        class_o[class_neg_zero_lp]     = sign  & decode_o.zero;
        class_o[class_pos_zero_lp]     = ~sign & decode_o.zero;
        class_o[class_pos_denormal_lp] = ~sign & decode_o.denormal;
        class_o[class_pos_normal_lp]   = ~sign & normal;
        class_o[class_pos_inf_lp]      = ~sign & decode_o.infty;
        class_o[class_snan_lp]         = decode_o.snan;
        class_o[class_qnan_lp]         = decode_o.nan & man[m_p-1];
    end

endmodule

// File: rtl/bsg_fpu_classify_pipe.sv
// Pipelined floating-point classifier: valid/ready in, one-deep result
// register, valid/yumi out, plus a sticky signalling-NaN flag.
// Optional per-class saturating counters are built when the macro
// BSG_FPU_CLASSIFY_PIPE_CNT_EN is defined.
module bsg_fpu_classify_pipe
    import bsg_fpu_classify_pkg::*;
#(
    parameter int e_p           = 5,
    parameter int m_p           = 10,
    parameter int class_width_p = 16,
    parameter int cnt_width_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [e_p+m_p:0]         a_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [class_width_p-1:0] class_o,
    input  logic                     yumi_i,
    input  logic                     clear_sticky_i,
    output logic                     sticky_invalid_o
`ifdef BSG_FPU_CLASSIFY_PIPE_CNT_EN
    ,
    input  logic [3:0]               cnt_sel_i,
    output logic [cnt_width_p-1:0]   cnt_o
`endif
);

    bsg_fpu_classify_s         dec_p0;
    logic [class_count_lp-1:0] onehot_p0;
    logic                      accept_p0;

    logic                      vld_p1;
    logic [class_count_lp-1:0] class_p1;
    logic                      sticky_r;

    bsg_fpu_classify_decode #(
        .e_p (e_p),
        .m_p (m_p)
    ) decode (
        .a_i      (a_i),
        .decode_o (dec_p0),
        .class_o  (onehot_p0)
    );

    // Only the sNaN flag drives state here; the rest of the struct is for other consumers.
    logic unused_dec_fields;
    assign unused_dec_fields = ^{dec_p0.zero, dec_p0.denormal, dec_p0.infty,
                                 dec_p0.nan, dec_p0.sign};

    assign ready_o   = ~vld_p1 | yumi_i;
    assign accept_p0 = v_i & ready_o;

    assign v_o              = vld_p1;
    assign class_o          = class_width_p'(class_p1);
    assign sticky_invalid_o = sticky_r;

    // Stage p0 -> p1: result register; a new accept overwrites, yumi alone drains.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_p1   <= 1'b0;
            class_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            class_p1 <= onehot_p0;
        end else if (yumi_i) begin
            vld_p1   <= 1'b0;
        end
    end

    // Sticky invalid flag; an accepted sNaN beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sticky_r <= 1'b0;
        end else if (accept_p0 & dec_p0.snan) begin
            sticky_r <= 1'b1;
        end else if (clear_sticky_i) begin
            sticky_r <= 1'b0;
        end
    end

`ifdef BSG_FPU_CLASSIFY_PIPE_CNT_EN
    logic [cnt_width_p-1:0] cnt_r [class_count_lp];

    // Per-class saturating counters; clear zeroes them but a same-cycle hit still counts once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < class_count_lp; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < class_count_lp; i++) begin
                if (clear_sticky_i) begin
                    cnt_r[i] <= (accept_p0 & onehot_p0[i]) ? cnt_width_p'(1) : '0;
                end else if (accept_p0 & onehot_p0[i] & ~(&cnt_r[i])) begin
                    cnt_r[i] <= cnt_r[i] + cnt_width_p'(1);
                end
            end
        end
    end

    // Counter readout; out-of-range selects read as zero.
    always_comb begin
        cnt_o = '0;
        if (cnt_sel_i < 4'(class_count_lp)) cnt_o = cnt_r[cnt_sel_i];
    end
`else
    localparam int unused_cnt_width_lp = cnt_width_p;
`endif

endmodule

// File: tb/tb_bsg_fpu_classify_pipe.sv
module tb_bsg_fpu_classify_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v_i, ready, v_o, yumi, clr, sticky;
    logic [15:0] a_i;
    logic [15:0] class_o;

    logic        v32, ready32, vo32, yumi32, clr32, sticky32;
    logic [31:0] a32;
    logic [15:0] class32;

`ifdef BSG_FPU_CLASSIFY_PIPE_CNT_EN
    logic [3:0]  cnt_sel, cnt_sel32;
    logic [1:0]  cnt;
    logic [15:0] cnt32;

    bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .class_width_p(16), .cnt_width_p(2)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .ready_o(ready),
        .v_o(v_o), .class_o(class_o), .yumi_i(yumi), .clear_sticky_i(clr),
        .sticky_invalid_o(sticky), .cnt_sel_i(cnt_sel), .cnt_o(cnt));

    bsg_fpu_classify_pipe #(.e_p(8), .m_p(23), .class_width_p(16), .cnt_width_p(16)) dut32 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v32), .a_i(a32), .ready_o(ready32),
        .v_o(vo32), .class_o(class32), .yumi_i(yumi32), .clear_sticky_i(clr32),
        .sticky_invalid_o(sticky32), .cnt_sel_i(cnt_sel32), .cnt_o(cnt32));
`else
    bsg_fpu_classify_pipe #(.e_p(5), .m_p(10), .class_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .ready_o(ready),
        .v_o(v_o), .class_o(class_o), .yumi_i(yumi), .clear_sticky_i(clr),
        .sticky_invalid_o(sticky));

    bsg_fpu_classify_pipe #(.e_p(8), .m_p(23), .class_width_p(16)) dut32 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v32), .a_i(a32), .ready_o(ready32),
        .v_o(vo32), .class_o(class32), .yumi_i(yumi32), .clear_sticky_i(clr32),
        .sticky_invalid_o(sticky32));
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer16(input logic [15:0] a, input logic [15:0] e, input string tag);
        v_i  = 1'b1;
        a_i  = a;
        yumi = 1'b1;
        tick();
        v_i  = 1'b0;
        chk({tag, "_v"}, 32'(v_o), 32'd1);
        chk(tag, 32'(class_o), 32'(e));
    endtask

    task automatic xfer32(input logic [31:0] a, input logic [15:0] e, input string tag);
        v32    = 1'b1;
        a32    = a;
        yumi32 = 1'b1;
        tick();
        v32    = 1'b0;
        chk({tag, "_v"}, 32'(vo32), 32'd1);
        chk(tag, 32'(class32), 32'(e));
    endtask

    logic [15:0] stream_a [8] = '{16'hFC00, 16'h3C00, 16'h8001, 16'h0000,
                                  16'h7C00, 16'h8000, 16'hBC00, 16'h0001};
    logic [15:0] stream_e [8] = '{16'h0001, 16'h0040, 16'h0004, 16'h0010,
                                  16'h0080, 16'h0008, 16'h0002, 16'h0020};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v_i = 1'b0; a_i = '0; yumi = 1'b0; clr = 1'b0;
        v32 = 1'b0; a32 = '0; yumi32 = 1'b0; clr32 = 1'b0;
`ifdef BSG_FPU_CLASSIFY_PIPE_CNT_EN
        cnt_sel = '0; cnt_sel32 = '0;
`endif
        tick();
        tick();
        chk("rst_v", 32'(v_o), 32'd0);
        chk("rst_class", 32'(class_o), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single transfers
        xfer16(16'hFC00, 16'h0001, "neg_inf");
        xfer16(16'h3C00, 16'h0040, "pos_norm");
        xfer16(16'h8001, 16'h0004, "neg_denorm");
        xfer16(16'h0000, 16'h0010, "pos_zero");
        chk("sticky_idle", 32'(sticky), 32'd0);

        // Sticky flag
        xfer16(16'h7D00, 16'h0100, "snan");
        chk("sticky_set", 32'(sticky), 32'd1);
        xfer16(16'h7E00, 16'h0200, "qnan");
        chk("sticky_hold", 32'(sticky), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sticky_clr", 32'(sticky), 32'd0);
        chk("drain_v", 32'(v_o), 32'd0);
        clr = 1'b1;
        xfer16(16'h7D00, 16'h0100, "snan_clr");
        clr = 1'b0;
        chk("sticky_set_wins", 32'(sticky), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            v_i  = 1'b1;
            a_i  = stream_a[i];
            yumi = 1'b1;
            #1;
            chk($sformatf("stream_ready%0d", i), 32'(ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream_v%0d", i), 32'(v_o), 32'd1);
            chk($sformatf("stream_cls%0d", i), 32'(class_o), 32'(stream_e[i]));
        end
        v_i = 1'b0;
        tick();
        chk("stream_end_v", 32'(v_o), 32'd0);

        // Backpressure
        v_i = 1'b1; a_i = 16'h3C00; yumi = 1'b0;
        tick();
        a_i = 16'hBC00;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_ready%0d", i), 32'(ready), 32'd0);
            chk($sformatf("bp_v%0d", i), 32'(v_o), 32'd1);
            chk($sformatf("bp_cls%0d", i), 32'(class_o), 32'h0040);
            tick();
        end
        yumi = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ready), 32'd1);
        tick();
        chk("bp_next_v", 32'(v_o), 32'd1);
        chk("bp_next_cls", 32'(class_o), 32'h0002);
        v_i = 1'b0;
        tick();
        chk("bp_drain_v", 32'(v_o), 32'd0);

        // Asynchronous reset while holding a result
        v_i = 1'b1; a_i = 16'h7D00; yumi = 1'b0;
        tick();
        v_i = 1'b0;
        chk("pre_rst_v", 32'(v_o), 32'd1);
        chk("pre_rst_sticky", 32'(sticky), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_v", 32'(v_o), 32'd0);
        chk("arst_class", 32'(class_o), 32'd0);
        chk("arst_sticky", 32'(sticky), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        xfer16(16'h8001, 16'h0004, "post_rst");

`ifdef BSG_FPU_CLASSIFY_PIPE_CNT_EN
        // Saturating counters
        for (int i = 0; i < 5; i++) xfer16(16'h3C00, 16'h0040, $sformatf("cnt_norm%0d", i));
        v_i = 1'b0;
        tick();
        cnt_sel = 4'd6;
        #1;
        chk("cnt_sat", 32'(cnt), 32'd3);
        cnt_sel = 4'd2;
        #1;
        chk("cnt_denorm", 32'(cnt), 32'd1);
        cnt_sel = 4'd12;
        #1;
        chk("cnt_oob", 32'(cnt), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt_sel = 4'd6;
        #1;
        chk("cnt_clr6", 32'(cnt), 32'd0);
        cnt_sel = 4'd2;
        #1;
        chk("cnt_clr2", 32'(cnt), 32'd0);
        clr = 1'b1;
        xfer16(16'h3C00, 16'h0040, "cnt_clr_inc");
        clr = 1'b0;
        cnt_sel = 4'd6;
        #1;
        chk("cnt_clr_inc_val", 32'(cnt), 32'd1);
`endif

        // Single precision instance
        xfer32(32'h7FC00000, 16'h0200, "sp_qnan");
        xfer32(32'hFF800000, 16'h0001, "sp_neg_inf");
        xfer32(32'h00000001, 16'h0020, "sp_pos_denorm");
        xfer32(32'h3F800000, 16'h0040, "sp_pos_norm");
        chk("sp_sticky_clear", 32'(sticky32), 32'd0);
        xfer32(32'h7F800001, 16'h0100, "sp_snan");
        chk("sp_sticky_set", 32'(sticky32), 32'd1);
        tick();
        chk("sp_drain_v", 32'(vo32), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_fpu_classify_pipe.md
Name: bsg_fpu_classify_pipe

Overview:
- Parametrised, pipelined floating-point classifier for any IEEE-style format (e_p exponent bits, m_p mantissa bits).
- Accepts operands through a valid/ready handshake and returns a registered one-hot RISC-V fclass result through a valid/yumi handshake.
- Keeps a sticky invalid flag that records any signalling NaN the block has seen.
- Sits between the operand buffer and the FPU result mux. Replaces the fixed half-precision combinational classifier.

Parameters:
- e_p, 5, exponent width (>=2)
- m_p, 10, mantissa width (>=2)
- class_width_p, 16, width of class_o (>=10); bits above 9 are tied to 0
- cnt_width_p, 16, per-class counter width; used only when the optional feature is enabled

Ports:
- clk_i  input  1  clock
- reset_n_i  input  1  asynchronous active-low reset
- v_i  input  1  operand valid
- a_i  input  e_p+m_p+1  operand {sign, exp, man}
- ready_o  output  1  block can accept an operand this cycle
- v_o  output  1  class result valid
- class_o  output  class_width_p  one-hot class result
- yumi_i  input  1  consumer takes the result; legal only when v_o=1
- clear_sticky_i  input  1  clears the sticky invalid flag
- sticky_invalid_o  output  1  an sNaN has been accepted since the last clear
- cnt_sel_i  input  4  counter index 0..9 (present only with the feature)
- cnt_o  output  cnt_width_p  selected counter value (present only with the feature)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: v_o=0, class_o=0, sticky_invalid_o=0, all counters 0. Reset asserted mid-transfer discards the held result; no partial state survives.
- Decode of a_i:
  - exp_zero = exp==0; exp_ones = exp all 1; man_zero = man==0.
  - zero = exp_zero & man_zero; denormal = exp_zero & ~man_zero.
  - infty = exp_ones & man_zero; nan = exp_ones & ~man_zero.
  - sNaN = nan & ~man[m_p-1]; qNaN = nan & man[m_p-1].
  - normal = none of the above.
- Class bit assignment:
  - Bits 0..3: -inf, -normal, -denormal, -zero.
  - Bits 4..7: +zero, +denormal, +normal, +inf.
  - Bit 8: sNaN; bit 9: qNaN. NaN bits ignore sign.
  - Exactly one bit is set whenever v_o=1.
- Handshake and timing:
  - One-deep pipeline register; ready_o = ~v_o | yumi_i.
  - Accept when v_i & ready_o; the result appears on class_o with v_o=1 on the next cycle. Latency is 1 cycle.
  - Accept and yumi_i in the same cycle: the new result replaces the old one with no bubble, giving full throughput.
  - yumi_i without accept: v_o goes to 0 next cycle; class_o holds its last value (don't-care).
  - While v_o=1 and yumi_i=0, class_o is stable and the input is not accepted.
- Sticky flag:
  - Set on the cycle after an accepted sNaN.
  - clear_sticky_i clears it on the next edge.
  - Clear and set in the same cycle: set wins.
- Width rules: class_o bits [class_width_p-1:10] are always 0. Widths are derived from e_p/m_p only; there are no hardcoded 16-bit assumptions.

Optional Feature:
- Macro: BSG_FPU_CLASSIFY_PIPE_CNT_EN.
- Enabled:
  - Ten saturating counters of cnt_width_p bits, one per class.
  - A counter increments by 1 on each accepted operand of its class and saturates at all-ones, with no wrap.
  - cnt_o = counter[cnt_sel_i], combinational. cnt_sel_i>9 returns 0.
  - clear_sticky_i also zeroes all counters. Clear and increment in the same cycle: the counter becomes 1.
- Disabled: no counters; cnt_sel_i and cnt_o are absent; everything else is identical.

Decomposition:
- Package bsg_fpu_classify_pkg:
  - localparam indices for the ten class bits (e.g. class_neg_inf_lp=0 ... class_qnan_lp=9).
  - class_count_lp=10.
  - A typedef'd struct {zero, denormal, infty, nan, snan, sign} used as the decoder output.
- Sub-module bsg_fpu_classify_decode (parametrised e_p, m_p): purely combinational decode of a_i into the struct plus the 10-bit one-hot.
- Top level holds the handshake register, the sticky flag and the optional counters.

Test Plan:
- e_p=5, m_p=10. Single transfers; yumi_i asserted each cycle:
  - a_i=16'hFC00 → class_o=16'h0001
  - a_i=16'h3C00 → class_o=16'h0040
  - a_i=16'h8001 → class_o=16'h0004
  - a_i=16'h0000 → class_o=16'h0010
- a_i=16'h7D00 → class_o=16'h0100 and sticky_invalid_o=1 from the next cycle. Then a_i=16'h7E00 → 16'h0200. Then clear_sticky_i for 1 cycle → sticky_invalid_o=0. Clear together with a new sNaN accept → flag stays 1.
- Back-to-back stream of 8 operands with yumi_i held high → 8 results on 8 consecutive cycles, in order, with ready_o constantly 1.
- Backpressure: yumi_i=0 for 3 cycles after a result appears → ready_o=0, class_o stable, next operand held off; it is accepted in the cycle yumi_i rises.
- reset_n_i pulsed low asynchronously while v_o=1 → v_o, class_o and sticky_invalid_o drop to 0 immediately. After release, the first accepted operand classifies correctly.
- With BSG_FPU_CLASSIFY_PIPE_CNT_EN and cnt_width_p=2:
  - Five +normal operands → cnt_sel_i=6 gives cnt_o=3 (saturated).
  - cnt_sel_i=12 gives cnt_o=0.
  - Then clear_sticky_i → all counters 0.
- Repeat a subset with e_p=8, m_p=23: 32'h7FC00000 → 16'h0200.
